// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit engine: one-entry holding buffer, frame sequencer, data
// shifter, stored parity bit and registered serial output. Bit timing comes
// from an external baud strobe; queued frames follow each other with no idle bit.
//
// Handshake: the producer presents i_data plus per-frame config with
// i_data_valid; a transfer happens on any rising edge where i_data_valid and
// o_data_ready are both high. The producer must hold data/config stable while
// i_data_valid is high and not yet accepted; o_data_ready does not depend on
// i_data_valid.
module uart_tx_frame_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_tick,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_data_valid,
   output logic                  o_data_ready,
   input  logic                  i_par_en,
   input  logic                  i_par_odd,
   input  logic                  i_stop2,
   output logic                  o_tx,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic [2:0]            dbg_state
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP1  = 3'd4,
      S_STOP2  = 3'd5
   } state_t;

   state_t                state;
   state_t                state_next;

   // holding buffer entry
   logic                  hold_full;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_par_en;
   logic                  hold_par_odd;
   logic                  hold_stop2;

   // in-flight frame
   logic [DATA_WIDTH-1:0] shifter;
   logic [DATA_WIDTH-1:0] shifter_next;
   logic [CW-1:0]         cnt;
   logic                  par_bit;
   logic                  par_en_q;
   logic                  stop2_q;

   logic                  frame_end;
   logic                  load;
   logic                  accept;
   logic                  tx_next;

   assign accept       = i_data_valid & ~hold_full;
   assign load         = hold_full & ((i_tick & (state == S_IDLE)) | frame_end);
   assign o_data_ready = ~hold_full;
   assign dbg_state    = state;

   // State register plus the line and done-pulse flops that track it
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         o_tx         <= 1'b1;
         o_frame_done <= 1'b0;
      end else begin
         state        <= state_next;
         o_tx         <= tx_next;
         o_frame_done <= frame_end;
      end
   end

   // Next-state logic; all moves happen on baud ticks, bad encodings fall to IDLE
   always_comb begin
      state_next = state;
      frame_end  = 1'b0;
      case (state)
         S_IDLE:   if (i_tick && hold_full) state_next = S_START;
         S_START:  if (i_tick) state_next = S_DATA;
         S_DATA:   if (i_tick && (cnt == LAST_BIT))
                      state_next = par_en_q ? S_PARITY : S_STOP1;
         S_PARITY: if (i_tick) state_next = S_STOP1;
         S_STOP1:  if (i_tick) begin
                      if (stop2_q) state_next = S_STOP2;
                      else         frame_end  = 1'b1;
                   end
         S_STOP2:  if (i_tick) frame_end = 1'b1;
         default:  state_next = S_IDLE;
      endcase
      // a queued entry starts immediately after the last stop bit
      if (frame_end) state_next = hold_full ? S_START : S_IDLE;
   end

   // Output decode: line level for the state being entered, busy from current state
   always_comb begin
      case (state_next)
         S_IDLE:   tx_next = 1'b1;
         S_START:  tx_next = 1'b0;
         S_DATA:   tx_next = shifter_next[0];
         S_PARITY: tx_next = par_bit;
         S_STOP1:  tx_next = 1'b1;
         S_STOP2:  tx_next = 1'b1;
         default:  tx_next = 1'b1;
      endcase
      o_busy = (state != S_IDLE);
   end

   // Shifter next value: load a new payload, or shift once per DATA tick
   always_comb begin
      shifter_next = shifter;
      if (load)
         shifter_next = hold_data;
      else if ((state == S_DATA) && i_tick)
         shifter_next = shifter >> 1;
   end

   // Holding buffer: capture on handshake, release when loaded into the shifter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_full    <= 1'b0;
         hold_data    <= '0;
         hold_par_en  <= 1'b0;
         hold_par_odd <= 1'b0;
         hold_stop2   <= 1'b0;
      end else if (load) begin
         hold_full <= 1'b0;
      end else if (accept) begin
         hold_full    <= 1'b1;
         hold_data    <= i_data;
         hold_par_en  <= i_par_en;
         hold_par_odd <= i_par_odd;
         hold_stop2   <= i_stop2;
      end
   end

   // Frame datapath: shifter, bit counter and config latched at load time
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shifter  <= '0;
         cnt      <= '0;
         par_bit  <= 1'b0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
      end else begin
         shifter <= shifter_next;
         if (load) begin
            cnt      <= '0;
            par_bit  <= (^hold_data) ^ hold_par_odd;
            par_en_q <= hold_par_en;
            stop2_q  <= hold_stop2;
         end else if ((state == S_DATA) && i_tick && (cnt != LAST_BIT)) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl: an 8-bit and a 5-bit instance,
// per-cycle line log, and immediate-assertion checks against hand-computed bit patterns.
module tb_uart_tx_frame_ctrl;

   localparam int LOG_N = 4096;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- DUT signals ----------------
   logic       tick;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       par_en;
   logic       par_odd;
   logic       stop2;
   logic       tx;
   logic       busy;
   logic       done;
   logic [2:0] state;

   logic [4:0] data5;
   logic       valid5;
   logic       ready5;
   logic       tx5;
   logic       busy5;
   logic       done5;
   logic [2:0] state5;
   logic       zero5;

   uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_data(data),
      .i_data_valid(valid), .o_data_ready(ready), .i_par_en(par_en),
      .i_par_odd(par_odd), .i_stop2(stop2), .o_tx(tx), .o_busy(busy),
      .o_frame_done(done), .dbg_state(state)
   );

   uart_tx_frame_ctrl #(.DATA_WIDTH(5)) dut5 (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_data(data5),
      .i_data_valid(valid5), .o_data_ready(ready5), .i_par_en(zero5),
      .i_par_odd(zero5), .i_stop2(zero5), .o_tx(tx5), .o_busy(busy5),
      .o_frame_done(done5), .dbg_state(state5)
   );

   // ---------------- baud tick generator ----------------
   // tick_period: 0 = never, 1 = held high, N = one pulse every N cycles
   int tick_period;
   initial begin
      int ph;
      ph   = 0;
      tick = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_period == 0) tick = 1'b0;
         else if (tick_period == 1) tick = 1'b1;
         else begin
            tick = (ph == 0);
            ph   = (ph + 1 >= tick_period) ? 0 : ph + 1;
         end
      end
   end

   // ---------------- per-cycle line log ----------------
   int   cyc;
   logic tx_log   [LOG_N];
   logic busy_log [LOG_N];
   logic done_log [LOG_N];
   initial begin
      cyc = 0;
      forever begin
         @(negedge clk);
         if (cyc < LOG_N) begin
            tx_log[cyc]   = tx;
            busy_log[cyc] = busy;
            done_log[cyc] = done;
         end
         cyc = cyc + 1;
      end
   end

   // ---------------- scoreboard ----------------
   int checks;
   int errors;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Extract the first busy window after 'start': line bits sampled mid-bit,
   // busy length, and frame_done pulses seen since 'start'.
   task automatic analyze(input int start, input int period, output logic [31:0] bits,
                          output int nbusy, output int ndone);
      int first;
      bits  = '0;
      nbusy = 0;
      ndone = 0;
      first = -1;
      for (int i = start; i < cyc && i < LOG_N; i++) begin
         if (done_log[i]) ndone++;
         if (first < 0 && busy_log[i]) first = i;
      end
      if (first >= 0) begin
         for (int i = first; i < cyc && i < LOG_N && busy_log[i]; i++) begin
            int k;
            k = i - first;
            if ((k % period) == (period / 2) && (k / period) < 32) bits[k / period] = tx_log[i];
            nbusy++;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Present one entry and return on the negedge after the accepting edge.
   task automatic push(input logic [7:0] d, input logic pe, input logic po, input logic s2);
      int n;
      data    = d;
      par_en  = pe;
      par_odd = po;
      stop2   = s2;
      valid   = 1'b1;
      n = 0;
      while (!ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("push_ready_timeout", (n >= 1000), 32'd0);
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < budget);
      check("frame_done_timeout", (n >= budget), 32'd0);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget);
      int n;
      n = 0;
      while (state !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("state_wait_timeout", (n >= budget), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] bits;
      int          nbusy;
      int          ndone;
      int          mark;
      int          n5;
      int          d5;
      logic [31:0] bits5;

      checks = 0;
      errors = 0;
      tick_period = 0;
      rst_n   = 1'b0;
      data    = '0;
      valid   = 1'b0;
      par_en  = 1'b0;
      par_odd = 1'b0;
      stop2   = 1'b0;
      data5   = '0;
      valid5  = 1'b0;
      zero5   = 1'b0;

      // reset values
      step(3);
      check("rst_tx", tx, 32'd1);
      check("rst_busy", busy, 32'd0);
      check("rst_ready", ready, 32'd1);
      check("rst_done", done, 32'd0);
      check("rst_state", state, 32'd0);
      rst_n = 1'b1;
      step(2);

      // ticks while idle with nothing queued do nothing
      tick_period = 16;
      mark = cyc;
      step(40);
      analyze(mark, 16, bits, nbusy, ndone);
      check("idle_ticks_busy", nbusy, 32'd0);
      check("idle_ticks_tx", tx, 32'd1);

      // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
      mark = cyc;
      push(8'hA5, 1'b0, 1'b0, 1'b0);
      check("8n1_ready_after_accept", ready, 32'd0);
      wait_done(400);
      step(2);
      analyze(mark, 16, bits, nbusy, ndone);
      check("8n1_bits", bits, 32'h34A);
      check("8n1_busy_cycles", nbusy, 32'd160);
      check("8n1_done_pulses", ndone, 32'd1);

      // 8E2 0xA5: parity 0, stop 1,1
      mark = cyc;
      push(8'hA5, 1'b1, 1'b0, 1'b1);
      wait_done(400);
      step(2);
      analyze(mark, 16, bits, nbusy, ndone);
      check("8e2_bits", bits, 32'hD4A);
      check("8e2_busy_cycles", nbusy, 32'd192);
      check("8e2_done_pulses", ndone, 32'd1);

      // 8O1 0xA5: parity 1
      mark = cyc;
      push(8'hA5, 1'b1, 1'b1, 1'b0);
      wait_done(400);
      step(2);
      analyze(mark, 16, bits, nbusy, ndone);
      check("8o1_bits", bits, 32'h74A);
      check("8o1_busy_cycles", nbusy, 32'd176);
      check("8o1_done_pulses", ndone, 32'd1);

      // 0x3C with even parity; config inputs flipped during DATA have no effect
      mark = cyc;
      push(8'h3C, 1'b1, 1'b0, 1'b0);
      wait_state(3'd2, 100);
      par_en  = 1'b0;
      par_odd = 1'b1;
      stop2   = 1'b1;
      wait_done(400);
      step(2);
      analyze(mark, 16, bits, nbusy, ndone);
      check("cfg_change_bits", bits, 32'h478);
      check("cfg_change_busy_cycles", nbusy, 32'd176);

      // back-to-back 0x00 then 0xFF with tick held high
      tick_period = 1;
      step(2);
      mark = cyc;
      data    = 8'h00;
      par_en  = 1'b0;
      par_odd = 1'b0;
      stop2   = 1'b0;
      valid   = 1'b1;
      @(negedge clk);
      check("b2b_ready_low_after_accept", ready, 32'd0);
      data = 8'hFF;
      @(negedge clk);
      check("b2b_ready_high_after_load", ready, 32'd1);
      @(negedge clk);
      check("b2b_ready_low_second_accept", ready, 32'd0);
      valid = 1'b0;
      wait_done(50);
      wait_done(50);
      step(2);
      analyze(mark, 1, bits, nbusy, ndone);
      check("b2b_bits", bits, 32'hFFA00);
      check("b2b_busy_cycles", nbusy, 32'd20);
      check("b2b_done_pulses", ndone, 32'd2);

      // reset during DATA of 0x81 with a second entry queued
      tick_period = 16;
      step(2);
      push(8'h81, 1'b0, 1'b0, 1'b0);
      wait_state(3'd2, 100);
      push(8'h42, 1'b0, 1'b0, 1'b0);
      step(20);
      check("pre_rst_hold_full", ready, 32'd0);
      check("pre_rst_tx_data0", tx, 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx", tx, 32'd1);
      check("mid_rst_busy", busy, 32'd0);
      check("mid_rst_ready", ready, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      mark = cyc;
      step(100);
      analyze(mark, 16, bits, nbusy, ndone);
      check("post_rst_no_frame", nbusy, 32'd0);
      check("post_rst_no_done", ndone, 32'd0);

      // 5-bit instance, 5N1 0x15: 0,1,0,1,0,1,1
      tick_period = 1;
      step(2);
      data5  = 5'h15;
      valid5 = 1'b1;
      @(negedge clk);
      valid5 = 1'b0;
      n5    = 0;
      d5    = 0;
      bits5 = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy5) begin
            if (n5 < 32) bits5[n5] = tx5;
            n5++;
         end
         if (done5) d5++;
      end
      check("w5_bits", bits5, 32'h6A);
      check("w5_frame_len", n5, 32'd7);
      check("w5_done_pulses", d5, 32'd1);
      check("w5_idle_tx", tx5, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame_ctrl.md
# uart_tx_frame_ctrl

Parametrised UART transmit engine for the UART_TX subsystem. It combines frame sequencing, a one-entry holding buffer, the data shifter, the parity generator and the serial output into one block. Data width is set per instance. Parity enable, parity sense and stop-bit count are selected per frame. Bit timing comes from an external baud strobe, and back-to-back frames are sent with no idle gap.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.

Ports:
- i_clk  in  1  system clock; all flops rise-edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_tick  in  1  baud strobe; one-cycle pulse per bit period (may be held high for one-bit-per-cycle operation).
- i_data  in  DATA_WIDTH  frame payload; sent LSB first.
- i_data_valid  in  1  payload/config valid.
- o_data_ready  out  1  holding buffer empty; transfer occurs when i_data_valid & o_data_ready.
- i_par_en  in  1  parity bit present in this frame.
- i_par_odd  in  1  1 = odd parity, 0 = even parity.
- i_stop2  in  1  1 = two stop bits, 0 = one stop bit.
- o_tx  out  1  serial line; idles high.
- o_busy  out  1  high while a frame is on the line.
- o_frame_done  out  1  one-cycle pulse at end of each frame's last stop bit.

## Operation
- Holding buffer:
  - One entry holds {data, par_en, par_odd, stop2}, captured on the handshake cycle.
  - o_data_ready = !hold_full.
  - hold_full clears on the cycle its contents load into the shifter.
  - A load and an accept never coincide, because ready is low while the entry is full.
- Config is latched per frame. Changing i_par_en, i_par_odd or i_stop2 has no effect on a frame already accepted.
- States and transitions. Every state transition happens only on a cycle with i_tick=1.
  - IDLE → START: when hold_full & i_tick. On that edge the entry loads into the shifter and frame config regs, and the bit counter clears.
  - START → DATA.
  - DATA:
    - On each tick: shift right, counter +1.
    - When counter == DATA_WIDTH-1 and tick: go to PARITY if par_en, else STOP1.
  - PARITY → STOP1.
  - STOP1 → STOP2 if stop2, else end-of-frame.
  - STOP2 → end-of-frame.
  - End-of-frame with hold_full: load the next entry and go directly to START (no idle bit).
  - End-of-frame with hold empty: go to IDLE.
- Parity bit = XOR of all DATA_WIDTH payload bits, XOR par_odd.
  - Computed from the payload at load time and stored; it is not recomputed from the shifting register.
- o_tx is registered and updated on the same edge as the state, so its value always reflects the current state:
  - IDLE = 1
  - START = 0
  - DATA = current shifter LSB
  - PARITY = stored parity bit
  - STOP1/STOP2 = 1
- o_busy = (state != IDLE), decoded from the registered state.
- o_frame_done: registered pulse, high for exactly the one cycle following the end-of-frame edge, including on back-to-back frames.
- The counter is $clog2(DATA_WIDTH) bits wide and does not wrap within a frame.
- An illegal or unreachable state encoding returns to IDLE with o_tx=1.

## Timing
- Reset values (asynchronous on i_rst_n low):
  - State IDLE, hold_full 0.
  - o_tx 1, o_busy 0, o_data_ready 1, o_frame_done 0.
  - Shifter, counter and config regs 0.
- Reset mid-frame forces o_tx high immediately and discards the in-flight frame and the buffered entry.
- Accept latency:
  - A handshake at edge N makes hold_full visible from cycle N+1.
  - START begins at the first edge after N with i_tick=1.
  - A tick coinciding with the handshake edge is not used.
- Frame length is 2 + DATA_WIDTH + par_en + stop2 ticks (8N1 = 10 ticks).
- o_data_ready rises the cycle after the load into the shifter. A producer can therefore queue frame n+1 during frame n, giving continuous line output.
- i_tick pulses arriving while IDLE with no data are ignored.
- With i_tick held high, each bit lasts exactly one cycle.

## Test plan
- 8N1, tick every 16 cycles, send 0xA5 → o_tx bit sequence 0,1,0,1,0,0,1,0,1,1.
  - Each bit lasts 16 cycles, o_busy is high for 160 cycles, and one o_frame_done pulse occurs.
- 8E2 with 0xA5 → parity bit 0 then stop bits 1,1 (12 bits).
  - 8O1 with 0xA5 → parity bit 1 (11 bits).
- Back-to-back 0x00 then 0xFF, valid held, i_tick tied high:
  - o_tx = 0, 0×8, 1, 0, 1×8, 1 with no idle cycle between frames.
  - o_data_ready drops for one cycle after each accept.
  - Two o_frame_done pulses.
- Config change mid-frame: send 0x3C with par_en=1, then toggle i_par_en to 0 during DATA → the parity bit is still sent (value 0, even).
- Reset asserted during DATA of frame 0x81 with a second entry buffered:
  - o_tx=1, o_busy=0 and o_data_ready=1 at once, with no further start bit after release.
- DATA_WIDTH=5 instance, 5N1 with 0x15 → o_tx 0,1,0,1,0,1,1; frame length 7 ticks.
